// File: rtl/mdio_master_if.sv
// Command/response bus between the MDIC register logic and the Clause-22 MDIO master.
interface mdio_master_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    logic              eni;
    logic              op_rd;
    logic              pre_sup;
    logic [ADDR_W-1:0] phy_addr;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] wdatai;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdatao;
    logic              rd_err;

    modport master (
        output eni, op_rd, pre_sup, phy_addr, reg_addr, wdatai,
        input  busy, done, rdatao, rd_err
    );

    modport slave (
        input  eni, op_rd, pre_sup, phy_addr, reg_addr, wdatai,
        output busy, done, rdatao, rd_err
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: divides clk down to MDC, serialises one read/write frame per
// accepted command and returns read data plus a no-PHY (turnaround) error flag.
module mdio_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    mdio_master_if.slave cmd,
    output logic         mdc_o,
    input  logic         mdio_i,
    output logic         mdio_o,
    output logic         mdio_oe
);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned FRM_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);
    localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(15);
    localparam bit               HAS_PRE  = (PRE_LEN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_e;

    state_e              state_q, state_d, nxt_state;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mdc_q, mdc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                op_rd_q, op_rd_d;
    logic [FRM_W-1:0]    tx_q, tx_d;
    logic [DATA_W-1:0]   rsh_q, rsh_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_err_q, rd_err_d;
    logic                mdio_o_q, mdio_o_d;
    logic                mdio_oe_q, mdio_oe_d;
    logic [FRM_W-1:0]    frame;
    logic                drive;

    assign cmd.busy   = busy_q;
    assign cmd.done   = done_q;
    assign cmd.rdatao = rdata_q;
    assign cmd.rd_err = rd_err_q;
    assign mdc_o      = mdc_q;
    assign mdio_o     = mdio_o_q;
    assign mdio_oe    = mdio_oe_q;

    // Next-state, divider, bit counter and pad drive
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        mdc_d     = mdc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        op_rd_d   = op_rd_q;
        tx_d      = tx_q;
        rsh_d     = rsh_q;
        rdata_d   = rdata_q;
        rd_err_d  = rd_err_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        nxt_state = state_q;
        drive     = 1'b0;
        frame     = {2'b01, (cmd.op_rd ? 2'b10 : 2'b01), cmd.phy_addr, cmd.reg_addr,
                     2'b10, cmd.wdatai};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cmd.eni) begin
                    op_rd_d   = cmd.op_rd;
                    rd_err_d  = 1'b0;
                    busy_d    = 1'b1;
                    mdc_d     = 1'b0;
                    div_d     = '0;
                    mdio_oe_d = 1'b1;
                    if (HAS_PRE && !cmd.pre_sup) begin
                        state_d  = S_PRE;
                        cnt_d    = PRE_LAST;
                        mdio_o_d = 1'b1;
                        tx_d     = frame;
                    end else begin
                        state_d  = S_HDR;
                        cnt_d    = HDR_LAST;
                        mdio_o_d = frame[FRM_W-1];
                        tx_d     = {frame[FRM_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!mdc_q) begin
                        // Rising MDC: the PHY's read turnaround and data are sampled here
                        mdc_d = 1'b1;
                        if (op_rd_q && state_q == S_TA && cnt_q == '0) rd_err_d = mdio_i;
                        if (op_rd_q && state_q == S_DATA) rsh_d = {rsh_q[DATA_W-2:0], mdio_i};
                    end else begin
                        mdc_d = 1'b0;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            case (state_q)
                                S_PRE:   begin nxt_state = S_HDR;  cnt_d = HDR_LAST; end
                                S_HDR:   begin nxt_state = S_TA;   cnt_d = TA_LAST;  end
                                S_TA:    begin nxt_state = S_DATA; cnt_d = DAT_LAST; end
                                default: nxt_state = S_DONE;
                            endcase
                        end
                        state_d = nxt_state;
                        if (nxt_state == S_DONE) begin
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            mdio_oe_d = 1'b0;
                            mdio_o_d  = 1'b1;
                            if (op_rd_q) rdata_d = rsh_q;
                        end else if (nxt_state == S_PRE) begin
                            mdio_o_d = 1'b1;
                        end else begin
                            // Reads release the line from the first turnaround bit onward
                            drive     = !(op_rd_q && (nxt_state == S_TA || nxt_state == S_DATA));
                            mdio_oe_d = drive;
                            mdio_o_d  = drive ? tx_q[FRM_W-1] : 1'b1;
                            tx_d      = {tx_q[FRM_W-2:0], 1'b0};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            mdc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_rd_q   <= 1'b0;
            tx_q      <= '0;
            rsh_q     <= '0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            mdc_q     <= mdc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            op_rd_q   <= op_rd_d;
            tx_q      <= tx_d;
            rsh_q     <= rsh_d;
            rdata_q   <= rdata_d;
            rd_err_q  <= rd_err_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: a PHY model with register memory on instance A
// (CLK_DIV=2, PRE_LEN=32) and a bare pulled-up line on instance B (CLK_DIV=1, PRE_LEN=0).
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdio_master_if ifa ();
    mdio_master_if ifb ();

    logic mdc_a, mdo_a, moe_a, mdi_a;
    logic mdc_b, mdo_b, moe_b, mdi_b;
    logic phy_en = 1'b1;
    logic phy_o  = 1'b1;
    logic phy_oe = 1'b0;

    assign mdi_a = moe_a ? mdo_a : ((phy_en && phy_oe) ? phy_o : 1'b1);
    assign mdi_b = moe_b ? mdo_b : 1'b1;

    mdio_master #(.CLK_DIV(2), .PRE_LEN(32)) dut_a (
        .clk(clk), .rst(rst), .cmd(ifa), .mdc_o(mdc_a),
        .mdio_i(mdi_a), .mdio_o(mdo_a), .mdio_oe(moe_a)
    );
    mdio_master #(.CLK_DIV(1), .PRE_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .cmd(ifb), .mdc_o(mdc_b),
        .mdio_i(mdi_b), .mdio_o(mdo_b), .mdio_oe(moe_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PHY model: decodes frames on MDC rise, drives turnaround/read data from MDC fall
    logic [15:0] mem [0:31];
    int          pst  = 0;
    int          hcnt = 0;
    int          dcnt = 0;
    logic [12:0] hdr  = '0;
    logic [17:0] wd   = '0;
    logic [15:0] rdv  = '0;

    always @(posedge mdc_a or negedge mdc_a or posedge rst) begin
        if (rst) begin
            pst    = 0;
            phy_oe = 1'b0;
            phy_o  = 1'b1;
        end else if (mdc_a) begin
            case (pst)
                0: if (!mdi_a) begin pst = 1; hcnt = 0; end
                1: begin
                    hdr = {hdr[11:0], mdi_a};
                    hcnt++;
                    if (hcnt == 13) begin
                        dcnt = 0;
                        if (hdr[11:10] == 2'b10) begin pst = 2; rdv = mem[hdr[4:0]]; end
                        else begin pst = 3; wd = '0; end
                    end
                end
                2: begin
                    dcnt++;
                    if (dcnt == 18) begin phy_oe = 1'b0; pst = 0; end
                end
                3: begin
                    wd = {wd[16:0], mdi_a};
                    dcnt++;
                    if (dcnt == 18) begin mem[hdr[4:0]] = wd[15:0]; pst = 0; end
                end
                default: pst = 0;
            endcase
        end else if (pst == 2) begin
            if (dcnt == 0) phy_oe = 1'b0;
            else if (dcnt == 1) begin phy_oe = 1'b1; phy_o = 1'b0; end
            else phy_o = rdv[17-dcnt];
        end
    end

    logic [63:0] cap_o, cap_oe;
    int          cap_n;
    logic [3:0]  mdc_seq;
    int          cyc;
    int          ndone;

    task automatic drive_cmd(input bit sel, input logic en, input logic rd, input logic ps,
                             input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wdat);
        if (!sel) begin
            ifa.op_rd = rd; ifa.pre_sup = ps; ifa.phy_addr = pa;
            ifa.reg_addr = ra; ifa.wdatai = wdat; ifa.eni = en;
        end else begin
            ifb.op_rd = rd; ifb.pre_sup = ps; ifb.phy_addr = pa;
            ifb.reg_addr = ra; ifb.wdatai = wdat; ifb.eni = en;
        end
    endtask

    task automatic issue(input bit sel, input logic rd, input logic ps,
                         input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wdat);
        drive_cmd(sel, 1'b1, rd, ps, pa, ra, wdat);
        @(posedge clk);
        #1;
        if (!sel) ifa.eni = 1'b0; else ifb.eni = 1'b0;
    endtask

    // Runs a frame to its done pulse, capturing {oe,o} at every MDC rise
    task automatic run(input string tag, input bit sel, input bit spam, input int budget,
                       output int ncyc);
        logic prev, cur, dn;
        bit   found;
        prev = 1'b0; found = 1'b0; ncyc = 0;
        cap_o = '0; cap_oe = '0; cap_n = 0; mdc_seq = '0;
        for (int i = 0; i < budget && !found; i++) begin
            if (spam && i < 240)
                drive_cmd(sel, 1'b1, 1'($urandom), 1'($urandom), 5'($urandom),
                          5'($urandom), 16'($urandom));
            else if (!sel) ifa.eni = 1'b0;
            else ifb.eni = 1'b0;
            @(posedge clk);
            #1;
            ncyc++;
            cur = sel ? mdc_b : mdc_a;
            dn  = sel ? ifb.done : ifa.done;
            if (i < 4) mdc_seq = {mdc_seq[2:0], cur};
            if (cur && !prev) begin
                cap_o  = {cap_o[62:0],  (sel ? mdo_b : mdo_a)};
                cap_oe = {cap_oe[62:0], (sel ? moe_b : moe_a)};
                cap_n++;
            end
            prev = cur;
            if (dn) found = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
    endtask

    initial begin
        drive_cmd(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
        drive_cmd(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
        @(posedge clk);
        #1;
        check("rst_busy",   64'(ifa.busy),   64'd0);
        check("rst_done",   64'(ifa.done),   64'd0);
        check("rst_rdatao", 64'(ifa.rdatao), 64'h0);
        check("rst_rd_err", 64'(ifa.rd_err), 64'd0);
        check("rst_pads",   64'({mdc_a, mdo_a, moe_a}), 64'b010);
        check("rst_pads_b", 64'({mdc_b, mdo_b, moe_b, ifb.busy}), 64'b0100);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: write with full preamble
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'hABCD);
        check("s1_start", 64'({ifa.busy, mdc_a, moe_a, mdo_a}), 64'b1011);
        run("s1", 1'b0, 1'b0, 400, cyc);
        check("s1_cycles", 64'(cyc), 64'd256);
        check("s1_end_pads", 64'({ifa.busy, mdc_a, moe_a, mdo_a}), 64'b0001);
        check("s1_nbits", 64'(cap_n), 64'd64);
        check("s1_bits", cap_o, 64'hFFFF_FFFF_5002_ABCD);
        check("s1_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        check("s1_mdc_seq", 64'(mdc_seq), 64'b0110);
        @(posedge clk);
        #1;
        check("s1_done_pulse", 64'(ifa.done), 64'd0);
        check("s1_mem0", 64'(mem[0]), 64'hABCD);

        // 2: read back
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 16'h0);
        run("s2", 1'b0, 1'b0, 400, cyc);
        check("s2_cycles", 64'(cyc), 64'd256);
        check("s2_oe", cap_oe, 64'hFFFF_FFFF_FFFC_0000);
        check("s2_bits", cap_o & cap_oe, 64'hFFFF_FFFF_6000_0000);
        @(posedge clk);
        #1;
        check("s2_rdatao", 64'(ifa.rdatao), 64'hABCD);
        check("s2_rd_err", 64'(ifa.rd_err), 64'd0);

        // 3: read with PHY absent, then a write clears rd_err on acceptance
        phy_en = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 16'h0);
        run("s3r", 1'b0, 1'b0, 400, cyc);
        @(posedge clk);
        #1;
        check("s3_rdatao", 64'(ifa.rdatao), 64'hFFFF);
        check("s3_rd_err", 64'(ifa.rd_err), 64'd1);
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 16'h1234);
        check("s3_err_clr", 64'(ifa.rd_err), 64'd0);
        check("s3_rdatao_kept", 64'(ifa.rdatao), 64'hFFFF);
        run("s3w", 1'b0, 1'b0, 400, cyc);
        check("s3_cycles", 64'(cyc), 64'd256);
        phy_en = 1'b1;
        check("s3_mem5", 64'(mem[5]), 64'h1234);

        // 4: preamble suppressed
        issue(1'b0, 1'b0, 1'b1, 5'd1, 5'd31, 16'h3C3C);
        check("s4_first_bit", 64'({moe_a, mdo_a}), 64'b10);
        run("s4", 1'b0, 1'b0, 400, cyc);
        check("s4_cycles", 64'(cyc), 64'd128);
        check("s4_nbits", 64'(cap_n), 64'd32);
        check("s4_bits", cap_o, 64'h0000_0000_50FE_3C3C);
        check("s4_mem31", 64'(mem[31]), 64'h3C3C);

        // 5: eni spammed during a frame must be ignored
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 16'h5A5A);
        run("s5", 1'b0, 1'b1, 400, cyc);
        check("s5_cycles", 64'(cyc), 64'd256);
        check("s5_bits", cap_o, 64'hFFFF_FFFF_500A_5A5A);
        check("s5_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done || ifa.busy) ndone++;
        end
        check("s5_no_extra", 64'(ndone), 64'd0);
        check("s5_mem2", 64'(mem[2]), 64'h5A5A);

        // 5b: reset in the middle of read data
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 16'h0);
        repeat (212) @(posedge clk);
        #1;
        check("s5_mid_busy", 64'(ifa.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s5_abort", 64'({ifa.busy, ifa.done, mdc_a, moe_a}), 64'b0000);
        check("s5_abort_rdatao", 64'(ifa.rdatao), 64'h0);
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done) ndone++;
        end
        check("s5_abort_nodone", 64'(ndone), 64'd0);
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 16'h0);
        run("s5r", 1'b0, 1'b0, 400, cyc);
        check("s5r_cycles", 64'(cyc), 64'd256);
        @(posedge clk);
        #1;
        check("s5r_rdatao", 64'(ifa.rdatao), 64'h5A5A);
        check("s5r_rd_err", 64'(ifa.rd_err), 64'd0);

        // 6: CLK_DIV=1, no preamble, back-to-back commands
        issue(1'b1, 1'b0, 1'b0, 5'd3, 5'd7, 16'h0F0F);
        run("s6w", 1'b1, 1'b0, 200, cyc);
        check("s6_cycles", 64'(cyc), 64'd64);
        check("s6_nbits", 64'(cap_n), 64'd32);
        check("s6_bits", cap_o, 64'h0000_0000_519E_0F0F);
        check("s6_mdc_seq", 64'(mdc_seq), 64'b1010);
        issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd7, 16'h0);
        check("s6_b2b_start", 64'({ifb.busy, mdc_b, moe_b}), 64'b101);
        run("s6r", 1'b1, 1'b0, 200, cyc);
        check("s6r_cycles", 64'(cyc), 64'd64);
        check("s6r_oe", cap_oe, 64'h0000_0000_FFFC_0000);
        @(posedge clk);
        #1;
        check("s6r_rdatao", 64'(ifb.rdatao), 64'hFFFF);
        check("s6r_rd_err", 64'(ifb.rd_err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised Clause-22 MDIO management master. Successor to the fixed-format shift_mdio serializer.
- Takes one read or write command at a time from the MDIC register logic (e1000_regs) and generates MDC. Serialises the frame on MDIO and returns read data plus a no-response flag.
- Adds the following over the existing serializer: configurable MDC divider, configurable preamble length, per-command preamble suppression, turnaround error detection, and reset-safe abort.

Parameters:
- CLK_DIV, 2, clk cycles per MDC half-period (>=1); MDC period = 2*CLK_DIV clk.
- PRE_LEN, 32, preamble bits of '1' sent before ST (0..32).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- eni  in  1  command strobe, accepted only when busy=0
- op_rd  in  1  1=read (OP 10), 0=write (OP 01); latched on accepted eni
- pre_sup  in  1  1=omit preamble for this command; latched on accepted eni
- phy_addr  in  5  PHYAD, latched on accepted eni
- reg_addr  in  5  REGAD, latched on accepted eni
- wdatai  in  16  write data, latched on accepted eni
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- rdatao  out  16  last read data, held until next read completes
- rd_err  out  1  read turnaround bit 2 sampled as 1 (no PHY); held until next accepted eni
- mdc_o  out  1  management clock
- mdio_i  in  1  MDIO pad input
- mdio_o  out  1  MDIO drive value
- mdio_oe  out  1  MDIO output enable

Behaviour:
- Reset values (the cycle after rst=1): busy=0, done=0, rdatao=16'h0000, rd_err=0, mdc_o=0, mdio_o=1, mdio_oe=0. State=IDLE.
- rst overrides everything, including mid-frame. The frame is abandoned with no done pulse.
- All outputs are registered.
- Frame is N bits:
  - N = PRE_LEN+32, or N = 32 when pre_sup=1 (also when PRE_LEN=0).
  - Bit order: preamble 1s, ST=01, OP, PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA, DATA[15:0] MSB first.
- TA:
  - Write: master drives 1,0.
  - Read: mdio_oe=0 for TA and DATA.
- Bit slot timing:
  - Each slot is 2*CLK_DIV clk: mdc_o=0 for the first CLK_DIV cycles, 1 for the next CLK_DIV cycles.
  - mdio_o/mdio_oe update on the same clk edge that drives mdc_o low (slot start).
  - mdio_i is sampled on the clk edge that drives mdc_o high.
- Command acceptance:
  - eni with busy=0 at edge T latches all command fields.
  - busy=1 and the first slot starts (mdc_o=0) from T+1.
  - eni while busy=1 is ignored and does not disturb the frame or the latched fields.
- Frame end:
  - After slot N ends, at cycle T+1+N*2*CLK_DIV: done=1 for one cycle, busy=0, mdc_o=0, mdio_oe=0, mdio_o=1.
  - A new eni in the same cycle that done=1 is accepted.
- States: IDLE -> PRE (skipped if N=32) -> HDR (14 bits ST/OP/PHY/REG) -> TA (2) -> DATA (16) -> DONE (1 cycle) -> IDLE.
- Divider and bit counters:
  - The divider counts 0..CLK_DIV-1 and wraps.
  - The bit counter counts down within each state. The transition happens on the wrap at the end of the high phase.
- Read results:
  - The second TA sample sets rd_err = mdio_i.
  - DATA samples shift into a shift register that is copied to rdatao in DONE.
  - With no PHY present, rdatao=16'hFFFF and rd_err=1.
- Writes leave rdatao unchanged. rd_err is cleared on every accepted eni.
- MDC is idle low when not busy; no free-running clock.

Test Plan:
1. Write PHY model (mdio_emu + memory) with CLK_DIV=2, PRE_LEN=32: eni, op_rd=0, phy=0, reg=0, wdata=16'hABCD -> 32 ones then 01 01 00000 00000 10 ABCD on mdio_o. mdio_oe=1 for all 64 bits. done exactly 256 cycles after the slot start; model memory[0]=16'hABCD.
2. Read phy=0, reg=0 after scenario 1 -> mdio_oe=0 from the TA slot. rdatao=16'hABCD, rd_err=0, done 256 cycles after start.
3. Read with PHY disconnected (mdio pulled to 1) -> rdatao=16'hFFFF, rd_err=1. A following write clears rd_err on acceptance.
4. pre_sup=1, write phy=1, reg=31, data=16'h3C3C -> first bits 0,1 with no preamble; done 128 cycles after start; memory[31]=16'h3C3C.
5. Pulse eni with different fields every cycle during a frame -> bitstream identical to the first command, with a single done.
   - Then assert rst mid-DATA -> next cycle busy=0, mdc_o=0, mdio_oe=0, no done.
   - A subsequent read frame completes correctly.
6. CLK_DIV=1, PRE_LEN=0 -> MDC period 2 clk, 32-bit frame, done 64 cycles after start.
   - Back-to-back eni issued on the done cycle -> next frame starts with no idle slot.
